// File: rtl/data_path.sv
// 5-stage MIPS-subset core (IF/ID/EX/MEM/WB) with ROM, regfile, ALU and data RAM; no forwarding.
// Latency: one instruction per cycle; a result is written back 4 edges after it is fetched into ID.
// Backpressure: RAW hazards stall IF/ID and inject a bubble into ID/EX until the producer reaches WB.
module data_path #(
   parameter logic [31:0] RESET_PC   = 32'd100,
   parameter int          DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   output logic [31:0] dinstOut,
   output logic        ewreg,
   output logic        em2reg,
   output logic        ewmem,
   output logic        ealuimm,
   output logic [3:0]  ealuc,
   output logic [4:0]  edestReg,
   output logic [31:0] eqa,
   output logic [31:0] eqb,
   output logic [31:0] eimm32,
   output logic        mwreg,
   output logic        mm2reg,
   output logic        mwmem,
   output logic [4:0]  mdestReg,
   output logic [31:0] mr,
   output logic [31:0] mqb,
   output logic        wwreg,
   output logic        wm2reg,
   output logic [4:0]  wdestReg,
   output logic [31:0] wr,
   output logic [31:0] wdo,
   output logic [1:0]  stall,
   output logic [31:0] wbData
);

   localparam int AW = $clog2(DMEM_WORDS);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   // Program image; word index is the byte PC divided by 4.
   function automatic logic [31:0] rom_word(input logic [29:0] widx);
      case (widx)
         30'd25:  rom_word = 32'h00221820; // add $3,$1,$2
         30'd26:  rom_word = 32'h01232022; // sub $4,$9,$3
         30'd27:  rom_word = 32'h00692825; // or  $5,$3,$9
         30'd28:  rom_word = 32'h00693026; // xor $6,$3,$9
         30'd29:  rom_word = 32'h00693824; // and $7,$3,$9
         default: rom_word = 32'h00000000;
      endcase
   endfunction

   function automatic logic [31:0] reg_init(input int idx);
      case (idx)
         1:       reg_init = 32'hA00000AA;
         2:       reg_init = 32'h10000011;
         3:       reg_init = 32'h20000022;
         4:       reg_init = 32'h30000033;
         5:       reg_init = 32'h40000044;
         6:       reg_init = 32'h50000055;
         7:       reg_init = 32'h60000066;
         8:       reg_init = 32'h70000077;
         9:       reg_init = 32'h80000088;
         10:      reg_init = 32'h90000099;
         default: reg_init = 32'h00000000;
      endcase
   endfunction

   function automatic logic [31:0] dmem_init(input int idx);
      case (idx)
         0:       dmem_init = 32'hA00000AA;
         1:       dmem_init = 32'h10000011;
         2:       dmem_init = 32'h20000022;
         3:       dmem_init = 32'h30000033;
         4:       dmem_init = 32'h40000044;
         default: dmem_init = 32'h00000000;
      endcase
   endfunction

   logic [31:0] regs [32];
   logic [31:0] dmem [DMEM_WORDS];

   // ID-stage fields of the held instruction
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   assign op    = dinstOut[31:26];
   assign rs    = dinstOut[25:21];
   assign rt    = dinstOut[20:16];
   assign rd    = dinstOut[15:11];
   assign funct = dinstOut[5:0];

   logic        d_wreg;
   logic        d_m2reg;
   logic        d_wmem;
   logic        d_aluimm;
   logic        d_regrt;
   logic        d_uses_rt;
   logic [3:0]  d_aluc;
   logic [4:0]  d_dest;
   logic [31:0] d_qa;
   logic [31:0] d_qb;
   logic [31:0] d_imm;

   // Control decode; anything unrecognised becomes a NOP that writes nothing.
   always_comb begin
      d_wreg    = 1'b0;
      d_m2reg   = 1'b0;
      d_wmem    = 1'b0;
      d_aluimm  = 1'b0;
      d_regrt   = 1'b0;
      d_uses_rt = 1'b0;
      d_aluc    = ALU_AND;
      case (op)
         OP_RTYPE: begin
            d_uses_rt = 1'b1;
            case (funct)
               6'h20: begin d_wreg = 1'b1; d_aluc = ALU_ADD; end
               6'h22: begin d_wreg = 1'b1; d_aluc = ALU_SUB; end
               6'h24: begin d_wreg = 1'b1; d_aluc = ALU_AND; end
               6'h25: begin d_wreg = 1'b1; d_aluc = ALU_OR;  end
               6'h26: begin d_wreg = 1'b1; d_aluc = ALU_XOR; end
               default: ;
            endcase
         end
         OP_LW: begin
            d_wreg   = 1'b1;
            d_m2reg  = 1'b1;
            d_aluimm = 1'b1;
            d_regrt  = 1'b1;
            d_aluc   = ALU_ADD;
         end
         OP_SW: begin
            d_wmem    = 1'b1;
            d_aluimm  = 1'b1;
            d_regrt   = 1'b1;
            d_uses_rt = 1'b1;
            d_aluc    = ALU_ADD;
         end
         OP_ADDI: begin
            d_wreg   = 1'b1;
            d_aluimm = 1'b1;
            d_regrt  = 1'b1;
            d_aluc   = ALU_ADD;
         end
         default: ;
      endcase
   end

   assign d_dest = d_regrt ? rt : rd;
   assign d_qa   = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign d_qb   = (rt == 5'd0) ? 32'd0 : regs[rt];
   assign d_imm  = {{16{dinstOut[15]}}, dinstOut[15:0]};

   // RAW detection against EX then MEM producers; WB producers are covered by the negedge write.
   logic hit_e;
   logic hit_m;
   assign hit_e = ewreg && (edestReg != 5'd0) &&
                  ((edestReg == rs) || (d_uses_rt && (edestReg == rt)));
   assign hit_m = mwreg && (mdestReg != 5'd0) &&
                  ((mdestReg == rs) || (d_uses_rt && (mdestReg == rt)));
   assign stall = hit_e ? 2'b01 : (hit_m ? 2'b10 : 2'b00);

   // IF stage: PC and IF/ID register hold while a hazard is outstanding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         dinstOut <= 32'd0;
      end else if (stall == 2'b00) begin
         pc       <= pc + 32'd4;
         dinstOut <= rom_word(pc[31:2]);
      end
   end

   // ID/EX register: a bubble (all zero) is inserted while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ewreg    <= 1'b0;
         em2reg   <= 1'b0;
         ewmem    <= 1'b0;
         ealuimm  <= 1'b0;
         ealuc    <= 4'd0;
         edestReg <= 5'd0;
         eqa      <= 32'd0;
         eqb      <= 32'd0;
         eimm32   <= 32'd0;
      end else if (stall != 2'b00) begin
         ewreg    <= 1'b0;
         em2reg   <= 1'b0;
         ewmem    <= 1'b0;
         ealuimm  <= 1'b0;
         ealuc    <= 4'd0;
         edestReg <= 5'd0;
         eqa      <= 32'd0;
         eqb      <= 32'd0;
         eimm32   <= 32'd0;
      end else begin
         ewreg    <= d_wreg;
         em2reg   <= d_m2reg;
         ewmem    <= d_wmem;
         ealuimm  <= d_aluimm;
         ealuc    <= d_aluc;
         edestReg <= d_dest;
         eqa      <= d_qa;
         eqb      <= d_qb;
         eimm32   <= d_imm;
      end
   end

   logic [31:0] alu_b;
   logic [31:0] alu_r;
   assign alu_b = ealuimm ? eimm32 : eqb;

   // ALU: wrapping arithmetic, no overflow detection.
   always_comb begin
      alu_r = 32'd0;
      case (ealuc)
         ALU_ADD: alu_r = eqa + alu_b;
         ALU_SUB: alu_r = eqa - alu_b;
         ALU_AND: alu_r = eqa & alu_b;
         ALU_OR:  alu_r = eqa | alu_b;
         ALU_XOR: alu_r = eqa ^ alu_b;
         default: alu_r = 32'd0;
      endcase
   end

   // EX/MEM register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mwreg    <= 1'b0;
         mm2reg   <= 1'b0;
         mwmem    <= 1'b0;
         mdestReg <= 5'd0;
         mr       <= 32'd0;
         mqb      <= 32'd0;
      end else begin
         mwreg    <= ewreg;
         mm2reg   <= em2reg;
         mwmem    <= ewmem;
         mdestReg <= edestReg;
         mr       <= alu_r;
         mqb      <= eqb;
      end
   end

   // Data RAM is word addressed; only the low address bits that fit the depth select a word.
   logic [AW-1:0] dmem_idx;
   logic [31:0]   mem_rd;
   assign dmem_idx = mr[AW+1:2];
   assign mem_rd   = dmem[dmem_idx];

   // Data RAM: reinitialised by reset, stores on the rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            dmem[i] <= dmem_init(i);
         end
      end else if (mwmem) begin
         dmem[dmem_idx] <= mqb;
      end
   end

   // MEM/WB register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wwreg    <= 1'b0;
         wm2reg   <= 1'b0;
         wdestReg <= 5'd0;
         wr       <= 32'd0;
         wdo      <= 32'd0;
      end else begin
         wwreg    <= mwreg;
         wm2reg   <= mm2reg;
         wdestReg <= mdestReg;
         wr       <= mr;
         wdo      <= mem_rd;
      end
   end

   assign wbData = wm2reg ? wdo : wr;

   // Register file: written on the falling edge so ID sees WB results in the same cycle.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= reg_init(i);
         end
      end else if (wwreg && (wdestReg != 5'd0)) begin
         regs[wdestReg] <= wbData;
      end
   end

   // PC byte offset and address bits beyond the RAM depth carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{pc[1:0], mr[1:0], mr[31:AW+2]};

endmodule

// File: tb/tb_data_path.sv
// Directed bench for the data_path pipeline: reset state, hazard stalls, ALU results, NOP run, mid-run reset.
// Outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived from the fixed ROM program and register init values.
module tb_data_path;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] dinstOut;
   logic        ewreg, em2reg, ewmem, ealuimm;
   logic [3:0]  ealuc;
   logic [4:0]  edestReg;
   logic [31:0] eqa, eqb, eimm32;
   logic        mwreg, mm2reg, mwmem;
   logic [4:0]  mdestReg;
   logic [31:0] mr, mqb;
   logic        wwreg, wm2reg;
   logic [4:0]  wdestReg;
   logic [31:0] wr, wdo;
   logic [1:0]  stall;
   logic [31:0] wbData;

   int total;
   int bad;

   data_path dut (
      .clk(clk), .rst(rst), .pc(pc), .dinstOut(dinstOut),
      .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
      .ealuc(ealuc), .edestReg(edestReg), .eqa(eqa), .eqb(eqb), .eimm32(eimm32),
      .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mdestReg(mdestReg),
      .mr(mr), .mqb(mqb), .wwreg(wwreg), .wm2reg(wm2reg), .wdestReg(wdestReg),
      .wr(wr), .wdo(wdo), .stall(stall), .wbData(wbData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (pc !== 32'd100) begin bad++; $display("FAIL rst_pc got=%0d want=100", pc); end
      total++; if (dinstOut !== 32'd0) begin bad++; $display("FAIL rst_dinst got=%h want=0", dinstOut); end
      total++; if (stall !== 2'b00) begin bad++; $display("FAIL rst_stall got=%b want=00", stall); end
      total++; if ({ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg} !== 13'd0) begin bad++; $display("FAIL rst_ectl got=%b want=0", {ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg}); end
      total++; if ({eqa, eqb, eimm32} !== 96'd0) begin bad++; $display("FAIL rst_edata got=%h want=0", {eqa, eqb, eimm32}); end
      total++; if ({mwreg, mm2reg, mwmem, mdestReg, mr, mqb} !== 72'd0) begin bad++; $display("FAIL rst_mem got=%h want=0", {mwreg, mm2reg, mwmem, mdestReg, mr, mqb}); end
      total++; if ({wwreg, wm2reg, wdestReg, wr, wdo, wbData} !== 103'd0) begin bad++; $display("FAIL rst_wb got=%h want=0", {wwreg, wm2reg, wdestReg, wr, wdo, wbData}); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Posedges 1 and 2: fetch add, then add enters EX while sub waits in ID.
   task automatic test_fetch();
      step();
      total++; if (pc !== 32'd104) begin bad++; $display("FAIL p1_pc got=%0d want=104", pc); end
      total++; if (dinstOut !== 32'h00221820) begin bad++; $display("FAIL p1_dinst got=%h want=00221820", dinstOut); end
      total++; if (stall !== 2'b00) begin bad++; $display("FAIL p1_stall got=%b want=00", stall); end
      step();
      total++; if (ealuc !== 4'b0010) begin bad++; $display("FAIL p2_ealuc got=%b want=0010", ealuc); end
      total++; if (edestReg !== 5'd3) begin bad++; $display("FAIL p2_edest got=%0d want=3", edestReg); end
      total++; if (eqa !== 32'hA00000AA) begin bad++; $display("FAIL p2_eqa got=%h want=A00000AA", eqa); end
      total++; if (eqb !== 32'h10000011) begin bad++; $display("FAIL p2_eqb got=%h want=10000011", eqb); end
      total++; if (eimm32 !== 32'h00001820) begin bad++; $display("FAIL p2_eimm got=%h want=00001820", eimm32); end
      total++; if ({ewreg, ealuimm} !== 2'b10) begin bad++; $display("FAIL p2_ectl got=%b want=10", {ewreg, ealuimm}); end
      total++; if (pc !== 32'd108) begin bad++; $display("FAIL p2_pc got=%0d want=108", pc); end
      total++; if (dinstOut !== 32'h01232022) begin bad++; $display("FAIL p2_dinst got=%h want=01232022", dinstOut); end
      total++; if (stall !== 2'b01) begin bad++; $display("FAIL p2_stall got=%b want=01", stall); end
   endtask

   // Posedges 3 and 4: two stall cycles with bubbles, then add reaches WB.
   task automatic test_stall();
      step();
      total++; if (stall !== 2'b10) begin bad++; $display("FAIL p3_stall got=%b want=10", stall); end
      total++; if (pc !== 32'd108) begin bad++; $display("FAIL p3_pc got=%0d want=108", pc); end
      total++; if (dinstOut !== 32'h01232022) begin bad++; $display("FAIL p3_dinst got=%h want=01232022", dinstOut); end
      total++; if ({ewreg, edestReg, eqa, eqb} !== 70'd0) begin bad++; $display("FAIL p3_bubble got=%h want=0", {ewreg, edestReg, eqa, eqb}); end
      total++; if (mr !== 32'hB00000BB) begin bad++; $display("FAIL p3_mr got=%h want=B00000BB", mr); end
      total++; if ({mwreg, mdestReg} !== 6'b1_00011) begin bad++; $display("FAIL p3_mdst got=%b want=100011", {mwreg, mdestReg}); end
      step();
      total++; if (wdestReg !== 5'd3) begin bad++; $display("FAIL p4_wdest got=%0d want=3", wdestReg); end
      total++; if ({wwreg, wm2reg} !== 2'b10) begin bad++; $display("FAIL p4_wctl got=%b want=10", {wwreg, wm2reg}); end
      total++; if (wbData !== 32'hB00000BB) begin bad++; $display("FAIL p4_wb got=%h want=B00000BB", wbData); end
      total++; if (stall !== 2'b00) begin bad++; $display("FAIL p4_stall got=%b want=00", stall); end
      total++; if (pc !== 32'd108) begin bad++; $display("FAIL p4_pc got=%0d want=108", pc); end
      total++; if (mwreg !== 1'b0) begin bad++; $display("FAIL p4_mbubble got=%b want=0", mwreg); end
   endtask

   // Posedges 5..10: sub, or, xor, and flow through with no further stalls.
   task automatic test_alu_ops();
      step();
      total++; if (eqa !== 32'h80000088) begin bad++; $display("FAIL p5_eqa got=%h want=80000088", eqa); end
      total++; if (eqb !== 32'hB00000BB) begin bad++; $display("FAIL p5_eqb got=%h want=B00000BB", eqb); end
      total++; if (ealuc !== 4'b0110) begin bad++; $display("FAIL p5_ealuc got=%b want=0110", ealuc); end
      total++; if (edestReg !== 5'd4) begin bad++; $display("FAIL p5_edest got=%0d want=4", edestReg); end
      total++; if (pc !== 32'd112) begin bad++; $display("FAIL p5_pc got=%0d want=112", pc); end
      total++; if (stall !== 2'b00) begin bad++; $display("FAIL p5_stall got=%b want=00", stall); end
      step();
      total++; if (mr !== 32'hCFFFFFCD) begin bad++; $display("FAIL p6_mr got=%h want=CFFFFFCD", mr); end
      total++; if (ealuc !== 4'b0001) begin bad++; $display("FAIL p6_ealuc got=%b want=0001", ealuc); end
      total++; if ({eqa, eqb} !== {32'hB00000BB, 32'h80000088}) begin bad++; $display("FAIL p6_eops got=%h want=B00000BB80000088", {eqa, eqb}); end
      total++; if (stall !== 2'b00) begin bad++; $display("FAIL p6_stall got=%b want=00", stall); end
      step();
      total++; if ({wdestReg, wbData} !== {5'd4, 32'hCFFFFFCD}) begin bad++; $display("FAIL p7_wb got=%h want=4/CFFFFFCD", {wdestReg, wbData}); end
      total++; if ({mdestReg, mr} !== {5'd5, 32'hB00000BB}) begin bad++; $display("FAIL p7_or got=%h want=5/B00000BB", {mdestReg, mr}); end
      total++; if (ealuc !== 4'b0011) begin bad++; $display("FAIL p7_ealuc got=%b want=0011", ealuc); end
      step();
      total++; if ({wdestReg, wbData} !== {5'd5, 32'hB00000BB}) begin bad++; $display("FAIL p8_wb got=%h want=5/B00000BB", {wdestReg, wbData}); end
      total++; if ({mdestReg, mr} !== {5'd6, 32'h30000033}) begin bad++; $display("FAIL p8_xor got=%h want=6/30000033", {mdestReg, mr}); end
      total++; if (dinstOut !== 32'd0) begin bad++; $display("FAIL p8_dinst got=%h want=0", dinstOut); end
      step();
      total++; if ({wdestReg, wbData} !== {5'd6, 32'h30000033}) begin bad++; $display("FAIL p9_wb got=%h want=6/30000033", {wdestReg, wbData}); end
      total++; if ({mdestReg, mr} !== {5'd7, 32'h80000088}) begin bad++; $display("FAIL p9_and got=%h want=7/80000088", {mdestReg, mr}); end
      total++; if (ewreg !== 1'b0) begin bad++; $display("FAIL p9_nop got=%b want=0", ewreg); end
      step();
      total++; if ({wwreg, wdestReg, wbData} !== {1'b1, 5'd7, 32'h80000088}) begin bad++; $display("FAIL p10_wb got=%h want=1/7/80000088", {wwreg, wdestReg, wbData}); end
   endtask

   // Posedges 11..20: only NOP words remain.
   task automatic test_nop_run();
      for (int k = 11; k <= 20; k++) begin
         step();
         total++; if ({stall, ewreg, mwreg, wwreg, ewmem, mwmem} !== 7'd0) begin bad++; $display("FAIL nop_ctl k=%0d got=%b want=0", k, {stall, ewreg, mwreg, wwreg, ewmem, mwmem}); end
         total++; if (pc !== 32'(100 + 4 * (k - 2))) begin bad++; $display("FAIL nop_pc k=%0d got=%0d want=%0d", k, pc, 100 + 4 * (k - 2)); end
      end
   endtask

   task automatic test_regfile();
      total++; if (dut.regs[3] !== 32'hB00000BB) begin bad++; $display("FAIL rf_r3 got=%h want=B00000BB", dut.regs[3]); end
      total++; if (dut.regs[4] !== 32'hCFFFFFCD) begin bad++; $display("FAIL rf_r4 got=%h want=CFFFFFCD", dut.regs[4]); end
      total++; if (dut.regs[5] !== 32'hB00000BB) begin bad++; $display("FAIL rf_r5 got=%h want=B00000BB", dut.regs[5]); end
      total++; if (dut.regs[6] !== 32'h30000033) begin bad++; $display("FAIL rf_r6 got=%h want=30000033", dut.regs[6]); end
      total++; if (dut.regs[7] !== 32'h80000088) begin bad++; $display("FAIL rf_r7 got=%h want=80000088", dut.regs[7]); end
      total++; if (dut.regs[8] !== 32'h70000077) begin bad++; $display("FAIL rf_r8 got=%h want=70000077", dut.regs[8]); end
      total++; if (dut.regs[0] !== 32'd0) begin bad++; $display("FAIL rf_r0 got=%h want=0", dut.regs[0]); end
   endtask

   // Reset asserted between edges must take effect without waiting for a clock.
   task automatic test_reset_mid();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++; if (pc !== 32'd100) begin bad++; $display("FAIL mid_pc got=%0d want=100", pc); end
      total++; if ({wwreg, wdestReg, wr, dinstOut} !== 70'd0) begin bad++; $display("FAIL mid_regs got=%h want=0", {wwreg, wdestReg, wr, dinstOut}); end
      total++; if (dut.regs[3] !== 32'h20000022) begin bad++; $display("FAIL mid_r3 got=%h want=20000022", dut.regs[3]); end
      total++; if (dut.regs[7] !== 32'h60000066) begin bad++; $display("FAIL mid_r7 got=%h want=60000066", dut.regs[7]); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Replays add->sub after reset: dependency must cost exactly 01 then 10.
   task automatic test_back_to_back();
      step();
      total++; if ({pc, dinstOut} !== {32'd104, 32'h00221820}) begin bad++; $display("FAIL b2b1 got=%h want=104/00221820", {pc, dinstOut}); end
      step();
      total++; if (stall !== 2'b01) begin bad++; $display("FAIL b2b2_stall got=%b want=01", stall); end
      total++; if (eqa !== 32'hA00000AA) begin bad++; $display("FAIL b2b2_eqa got=%h want=A00000AA", eqa); end
      step();
      total++; if (stall !== 2'b10) begin bad++; $display("FAIL b2b3_stall got=%b want=10", stall); end
      step();
      total++; if ({stall, wbData} !== {2'b00, 32'hB00000BB}) begin bad++; $display("FAIL b2b4 got=%h want=0/B00000BB", {stall, wbData}); end
      step();
      total++; if ({ewreg, edestReg, pc} !== {1'b1, 5'd4, 32'd112}) begin bad++; $display("FAIL b2b5 got=%h want=1/4/112", {ewreg, edestReg, pc}); end
      total++; if (eqb !== 32'hB00000BB) begin bad++; $display("FAIL b2b5_eqb got=%h want=B00000BB", eqb); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      test_reset();
      test_fetch();
      test_stall();
      test_alu_ops();
      test_nop_run();
      test_regfile();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
